// File: rtl/rng_code_checker.sv
// rtl/rng_code_checker.sv - loads a 4-digit code from the RNG block, checks entered digits, enforces lockout
// Optional feature: define ENTRY_TIMEOUT_EN to fail an attempt after TIMEOUT_CYCLES idle cycles in ENTRY.
module rng_code_checker #(
  parameter int W              = 4,
  parameter int LOAD_WAIT      = 1,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           rng_load,
  input  logic [W-1:0]                   rng_1,
  input  logic [W-1:0]                   rng_2,
  input  logic [W-1:0]                   rng_3,
  input  logic [W-1:0]                   key,
  input  logic                           digit_valid,
  input  logic [W-1:0]                   digit,
  output logic                           digit_ready,
  output logic                           pass,
  output logic                           fail,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int WW = $clog2(LOAD_WAIT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ENTRY, S_RESULT, S_LOCK} state_t;

  state_t        state;
  logic [W-1:0]  target [4];
  logic [1:0]    idx;
  logic          mismatch;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;

  logic accept;
  logic mism_now;
  logic timeout_hit;
  logic attempt_done;
  logic attempt_bad;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (state != S_ENTRY || accept)
      to_cnt <= '0;
    else if (!timeout_hit)
      to_cnt <= to_cnt + TOW'(1);
  end

  assign timeout_hit = (state == S_ENTRY) && !accept && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    accept       = digit_valid & digit_ready;
    mism_now     = mismatch | (digit != target[idx]);
    attempt_done = (state == S_ENTRY) && ((accept && idx == 2'd3) || timeout_hit);
    attempt_bad  = timeout_hit | mism_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rng_load    <= 1'b0;
      digit_ready <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      locked      <= 1'b0;
      tries_left  <= TW'(MAX_TRIES);
      idx         <= '0;
      mismatch    <= 1'b0;
      wait_cnt    <= '0;
      lock_cnt    <= '0;
      for (int i = 0; i < 4; i++) target[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQ;
            rng_load <= 1'b1;
          end
        end
        S_REQ: begin
          rng_load <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WW'(LOAD_WAIT - 1)) begin
            target[0]   <= rng_1;
            target[1]   <= rng_2;
            target[2]   <= rng_3;
            target[3]   <= key;
            idx         <= '0;
            mismatch    <= 1'b0;
            digit_ready <= 1'b1;
            state       <= S_ENTRY;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_ENTRY: begin
          if (accept) begin
            mismatch <= mism_now;
            idx      <= idx + 2'd1;
          end
          if (attempt_done) begin
            digit_ready <= 1'b0;
            pass        <= ~attempt_bad;
            fail        <= attempt_bad;
            tries_left  <= attempt_bad ? tries_left - TW'(1) : TW'(MAX_TRIES);
            state       <= S_RESULT;
          end
        end
        S_RESULT: begin
          pass <= 1'b0;
          fail <= 1'b0;
          if (!fail) begin
            state <= S_IDLE;
          end else if (tries_left == '0) begin
            locked   <= 1'b1;
            lock_cnt <= '0;
            state    <= S_LOCK;
          end else begin
            idx         <= '0;
            mismatch    <= 1'b0;
            digit_ready <= 1'b1;
            state       <= S_ENTRY;
          end
        end
        S_LOCK: begin
          if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            locked     <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
            for (int i = 0; i < 4; i++) target[i] <= '0;
            state      <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_code_checker.sv
// tb/tb_rng_code_checker.sv - directed self-checking bench for rng_code_checker
module tb_rng_code_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rng_load;
  logic [3:0] rng_1, rng_2, rng_3, key;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       pass, fail, locked;
  logic [1:0] tries_left;

  int total = 0;
  int bad   = 0;

  rng_code_checker dut (
    .clk(clk), .rst(rst), .start(start), .rng_load(rng_load),
    .rng_1(rng_1), .rng_2(rng_2), .rng_3(rng_3), .key(key),
    .digit_valid(digit_valid), .digit(digit), .digit_ready(digit_ready),
    .pass(pass), .fail(fail), .locked(locked), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives four digits on consecutive cycles, leaving digit_valid low afterwards.
  task automatic enter4(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) begin
      digit_valid = 1'b1;
      digit       = c[15-4*i -: 4];
      step(1);
    end
    digit_valid = 1'b0;
  endtask

  // start pulse through to first ENTRY cycle; checks the load pulse timing.
  task automatic load_code(input string tag);
    start = 1'b1;
    step(1);
    chk({tag, "_load_hi"}, {7'd0, rng_load}, 8'd1);
    start = 1'b0;
    step(1);
    chk({tag, "_load_lo"}, {7'd0, rng_load}, 8'd0);
    chk({tag, "_wait_rdy"}, {7'd0, digit_ready}, 8'd0);
    step(1);
    chk({tag, "_entry_rdy"}, {7'd0, digit_ready}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = 4'h0;
    rng_1 = 4'h3; rng_2 = 4'hA; rng_3 = 4'h7; key = 4'hC;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_load",   {7'd0, rng_load},    8'd0);
    chk("rst_ready",  {7'd0, digit_ready}, 8'd0);
    chk("rst_pulses", {5'd0, pass, fail, locked}, 8'd0);
    chk("rst_tries",  {6'd0, tries_left},  8'd3);

    // digits offered in IDLE are dropped
    digit_valid = 1'b1; digit = 4'h3;
    step(2);
    digit_valid = 1'b0;
    chk("idle_ready", {7'd0, digit_ready}, 8'd0);

    // correct code; RNG changes after capture must not matter
    load_code("p1");
    rng_1 = 4'h0; rng_2 = 4'h0; rng_3 = 4'h0; key = 4'h0;
    enter4(16'h3A7C);
    chk("p1_pass",  {6'd0, pass, fail}, 8'b10);
    chk("p1_tries", {6'd0, tries_left}, 8'd3);
    chk("p1_rdy",   {7'd0, digit_ready}, 8'd0);
    step(1);
    chk("p1_pulse_end", {6'd0, pass, fail}, 8'b00);
    chk("p1_idle_rdy",  {7'd0, digit_ready}, 8'd0);

    // fail path to lockout; digit_valid held high through WAIT must be dropped
    rng_1 = 4'h3; rng_2 = 4'hA; rng_3 = 4'h7; key = 4'hC;
    start = 1'b1;
    step(1);
    chk("f_load_hi", {7'd0, rng_load}, 8'd1);
    start = 1'b0;
    digit_valid = 1'b1; digit = 4'h3;
    step(2);
    chk("f_entry_rdy", {7'd0, digit_ready}, 8'd1);
    start = 1'b1;
    digit = 4'h3; step(1);
    chk("f_start_ignored", {7'd0, rng_load}, 8'd0);
    start = 1'b0;
    digit = 4'hA; step(1);
    digit = 4'h7; step(1);
    chk("f_not_done", {6'd0, pass, fail}, 8'b00);
    digit = 4'hD; step(1);
    digit_valid = 1'b0;
    chk("f1_fail",  {6'd0, pass, fail}, 8'b01);
    chk("f1_tries", {6'd0, tries_left}, 8'd2);
    step(1);
    chk("f1_reentry", {6'd0, digit_ready, fail}, 8'b10);
    enter4(16'h3A7D);
    chk("f2_fail",  {6'd0, pass, fail}, 8'b01);
    chk("f2_tries", {6'd0, tries_left}, 8'd1);
    step(1);
    enter4(16'hC7A3);
    chk("f3_fail",  {6'd0, pass, fail}, 8'b01);
    chk("f3_tries", {6'd0, tries_left}, 8'd0);
    digit_valid = 1'b1; digit = 4'h3;
    step(1);
    chk("lock_first", {6'd0, locked, digit_ready}, 8'b10);
    step(15);
    chk("lock_last", {6'd0, locked, digit_ready}, 8'b10);
    digit_valid = 1'b0;
    step(1);
    chk("lock_exit",  {7'd0, locked}, 8'd0);
    chk("lock_tries", {6'd0, tries_left}, 8'd3);
    chk("lock_idle",  {7'd0, digit_ready}, 8'd0);

    // reset mid-entry, then a fresh code
    rng_1 = 4'h1; rng_2 = 4'h2; rng_3 = 4'h3; key = 4'h4;
    load_code("r1");
    digit_valid = 1'b1; digit = 4'h1; step(1);
    digit = 4'h2; step(1);
    rst = 1'b1;
    #1;
    chk("r_async_rdy", {7'd0, digit_ready}, 8'd0);
    step(1);
    chk("r_pulses", {5'd0, pass, fail, locked}, 8'd0);
    chk("r_tries",  {6'd0, tries_left}, 8'd3);
    rst = 1'b0; digit_valid = 1'b0;
    rng_1 = 4'h5; rng_2 = 4'h6; rng_3 = 4'h7; key = 4'h8;
    step(1);
    load_code("r2");
    enter4(16'h5678);
    chk("r2_pass", {6'd0, pass, fail}, 8'b10);
    step(1);

    // one failure followed by success restores the full try count
    rng_1 = 4'h9; rng_2 = 4'h0; rng_3 = 4'hF; key = 4'hE;
    load_code("s1");
    enter4(16'h90FF);
    chk("s1_fail",  {6'd0, pass, fail}, 8'b01);
    chk("s1_tries", {6'd0, tries_left}, 8'd2);
    step(1);
    enter4(16'h90FE);
    chk("s1_pass",  {6'd0, pass, fail}, 8'b10);
    chk("s1_tries_restored", {6'd0, tries_left}, 8'd3);
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
